pe_simple_top: RTL and testbench
================================

# pe_simple_top

Single-issue processing-element wrapper combining an integer ALU, an activation/MAC unit, a comparator and a 32×32-bit register file. It executes one operation per accepted input and presents a registered result with a valid flag. A side port writes results or external data into the register file, and two asynchronous read ports expose register contents. It is the top-level test target of the PE subsystem.

## Interface
- No parameters (data width 32, 32 registers, fixed).
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- test_opcode  input  32  instruction word (fields below)
- test_op1  input  32  operand A
- test_op2  input  32  operand B
- test_op3  input  32  operand C (MAC addend)
- test_valid  input  1  operation request, sampled each rising edge
- test_result  output  32  registered result
- test_valid_out  output  1  registered valid
- rf_r1  output  32  RF[rf_wr_addr], combinational
- rf_r2  output  32  RF[test_opcode[14:10]], combinational
- rf_wr_addr  input  5  register-file write/observe address
- rf_wr_data  input  32  external write data
- rf_wr_en  input  1  register-file write enable

## Operation
- Opcode fields: class = [26:20], func = [19:15], rs1 = [14:10], rs2 = [9:5], rd = [4:0]. Bits [31:27] are ignored. rs2 and rd are decoded but unused; operands always come from test_op1/2/3.
- Class 7'b0000001, ALU:
  - func 1 ADD, 2 SUB (A−B), 3 MUL (low 32 bits)
  - func 4 AND, 5 OR, 6 XOR
  - func 7 SLL, 8 SRL, 9 SRA; shift amount is B[4:0]
- Class 7'b0000010, activation/MAC, signed:
  - func 11 (5'b01011) RELU: A if A ≥ 0, else 0
  - func 12 MAX(A,B), 13 MIN(A,B)
  - func 14 MAC: A*B+C, low 32 bits
- Class 7'b0010000, compare, result 1 or 0:
  - func 1 EQ, 2 NE, 3 LT signed, 4 LTU, 5 GE signed
- Any other class or func: result 0, valid still asserted.
- Arithmetic wraps modulo 2^32; there are no overflow flags.
- Register file: 32×32 bits, reset to all zeros. Writes to address 0 are ignored, so RF[0] always reads 0.
  - rf_wr_en & test_valid: RF[rf_wr_addr] ← computed result of the current inputs (write-back).
  - rf_wr_en & !test_valid: RF[rf_wr_addr] ← rf_wr_data.
  - Exactly one write per edge. Write-back has priority over the external write.
- Read ports are combinational and return the updated value after the write edge. Write-first bypass is not required.

## Timing
- Reset (rst high at a rising edge): test_result = 0, test_valid_out = 0, all RF entries = 0. Reset overrides any simultaneous valid or write, and aborts an in-flight op with no write.
- Latency is 1 cycle. On each edge, test_valid_out ← test_valid. If test_valid = 1, test_result ← f(inputs).
- While test_valid = 0, test_result holds its last value and test_valid_out = 0.
- There is no backpressure; a new op is accepted every cycle.
- Holding the inputs for N cycles repeats the op, giving a stable result and N repeated identical writes.
- Result is stable from the edge after acceptance until the edge after the inputs change.

## Test plan
- Reset, then class 1 func 1, A=10, B=20, held for 2 edges → result 30, valid_out 1; valid_out 0 one cycle after test_valid drops.
- ADD with A=15, B=25, rf_wr_en=1, rf_wr_addr=5 → result 40; rf_r1 = 40 afterwards; RF[0] stays 0 when addr = 0 is written.
- SUB 100−30 → 70. MUL 12×5 → 60. MUL 0x10000×0x10000 → 0 (wrap).
- RELU A=25 → 25. RELU A=−25 (0xFFFFFFE7) → 0. MAC 3×4+5 → 17.
- EQ 42,42 → 1. EQ 42,0 → 0. LT −1,0 → 1. LTU 0xFFFFFFFF,0 → 0.
- Assert rst mid-operation → outputs 0 on that edge and RF cleared. Unknown class 7'b1111111 → result 0, valid_out 1.

Source files
------------

// File: rtl/pe_simple_top_if.sv
// Request/response bundle of the PE wrapper: opcode/operands in, registered
// result out, plus the register-file side write port and its two read ports.
interface pe_simple_top_if;
  logic [31:0] test_opcode;
  logic [31:0] test_op1;
  logic [31:0] test_op2;
  logic [31:0] test_op3;
  logic        test_valid;
  logic [31:0] test_result;
  logic        test_valid_out;
  logic [31:0] rf_r1;
  logic [31:0] rf_r2;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_wr_en;

  modport master (
    output test_opcode, test_op1, test_op2, test_op3, test_valid,
    output rf_wr_addr, rf_wr_data, rf_wr_en,
    input  test_result, test_valid_out, rf_r1, rf_r2
  );

  modport slave (
    input  test_opcode, test_op1, test_op2, test_op3, test_valid,
    input  rf_wr_addr, rf_wr_data, rf_wr_en,
    output test_result, test_valid_out, rf_r1, rf_r2
  );
endinterface

// File: rtl/pe_simple_top.sv
// Single-issue PE: ALU, activation/MAC and compare units feeding a registered
// result, with a 32x32 register file written by write-back or external data.
module pe_simple_top (
  input logic             clk,
  input logic             rst,
  pe_simple_top_if.slave  bus
);

  localparam logic [6:0] CLS_ALU = 7'b0000001;
  localparam logic [6:0] CLS_ACT = 7'b0000010;
  localparam logic [6:0] CLS_CMP = 7'b0010000;

  logic [6:0]  cls_s;
  logic [4:0]  func_s;
  logic [4:0]  rs1_s;
  logic        unused_bits_s;
  logic [31:0] result_d;
  logic [31:0] result_q;
  logic        valid_out_q;
  logic [31:0] rf_q [32];

  function automatic logic [31:0] alu_f(input logic [4:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (fn)
      5'd1:    r = a + b;
      5'd2:    r = a - b;
      5'd3:    r = a * b;
      5'd4:    r = a & b;
      5'd5:    r = a | b;
      5'd6:    r = a ^ b;
      5'd7:    r = a << b[4:0];
      5'd8:    r = a >> b[4:0];
      5'd9:    r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Activation/MAC operands are interpreted as signed two's complement.
  function automatic logic [31:0] act_f(input logic [4:0] fn, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    case (fn)
      5'd11:   r = a[31] ? 32'd0 : a;
      5'd12:   r = ($signed(a) > $signed(b)) ? a : b;
      5'd13:   r = ($signed(a) < $signed(b)) ? a : b;
      5'd14:   r = a * b + c;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] cmp_f(input logic [4:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic bit_s;
    logic hit_s;
    hit_s = 1'b1;
    case (fn)
      5'd1:    bit_s = (a == b);
      5'd2:    bit_s = (a != b);
      5'd3:    bit_s = ($signed(a) < $signed(b));
      5'd4:    bit_s = (a < b);
      5'd5:    bit_s = ($signed(a) >= $signed(b));
      default: begin
        bit_s = 1'b0;
        hit_s = 1'b0;
      end
    endcase
    return {31'd0, bit_s & hit_s};
  endfunction

  assign cls_s  = bus.test_opcode[26:20];
  assign func_s = bus.test_opcode[19:15];
  assign rs1_s  = bus.test_opcode[14:10];
  // rs2/rd and the top bits carry no meaning here; operands come from test_op*.
  assign unused_bits_s = ^{bus.test_opcode[31:27], bus.test_opcode[9:0]};

  // Result selection by instruction class.
  always_comb begin
    result_d = 32'd0;
    case (cls_s)
      CLS_ALU: result_d = alu_f(func_s, bus.test_op1, bus.test_op2);
      CLS_ACT: result_d = act_f(func_s, bus.test_op1, bus.test_op2, bus.test_op3);
      CLS_CMP: result_d = cmp_f(func_s, bus.test_op1, bus.test_op2);
      default: result_d = 32'd0;
    endcase
  end

  // Result/valid registers and the register file; write-back beats external data.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 32'd0;
      valid_out_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      valid_out_q <= bus.test_valid;
      if (bus.test_valid) begin
        result_q <= result_d;
      end else begin
        result_q <= result_q;
      end
      if (bus.rf_wr_en && (bus.rf_wr_addr != 5'd0)) begin
        rf_q[bus.rf_wr_addr] <= bus.test_valid ? result_d : bus.rf_wr_data;
      end
    end
  end

  assign bus.test_result    = result_q;
  assign bus.test_valid_out = valid_out_q;
  assign bus.rf_r1          = rf_q[bus.rf_wr_addr];
  assign bus.rf_r2          = rf_q[rs1_s];

endmodule

// File: tb/tb_pe_simple_top.sv
// Directed self-checking bench for pe_simple_top with hand-computed expectations.
module tb_pe_simple_top;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pe_simple_top_if bus ();

  pe_simple_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  cls;
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] mk(input logic [6:0] cls, input logic [4:0] fn,
                                     input logic [4:0] rs1);
    return {5'd0, cls, fn, rs1, 10'd0};
  endfunction

  // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic v, input logic wen,
                      input logic [4:0] addr, input logic [31:0] data);
    bus.test_opcode = op;
    bus.test_op1    = a;
    bus.test_op2    = b;
    bus.test_op3    = c;
    bus.test_valid  = v;
    bus.rf_wr_en    = wen;
    bus.rf_wr_addr  = addr;
    bus.rf_wr_data  = data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(mk(7'd1, 5'd1, 5'd0), 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 5'd5, 32'd0);
    step(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5, 32'd0);
    rst = 1'b0;
    total++;
    if (bus.test_result !== 32'd0) begin
      bad++;
      $display("FAIL reset_result got=%h want=%h", bus.test_result, 32'd0);
    end
    total++;
    if (bus.test_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b want=0", bus.test_valid_out);
    end
    total++;
    if (bus.rf_r1 !== 32'd0) begin
      bad++;
      $display("FAIL reset_rf5 got=%h want=0", bus.rf_r1);
    end
  endtask

  task automatic test_add_hold;
    for (int i = 0; i < 2; i++) begin
      step(mk(7'd1, 5'd1, 5'd0), 32'd10, 32'd20, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus.test_result !== 32'd30 || bus.test_valid_out !== 1'b1) begin
        bad++;
        $display("FAIL add_hold[%0d] got=%h/%b want=%h/1", i, bus.test_result,
                 bus.test_valid_out, 32'd30);
      end
    end
    step(mk(7'd1, 5'd2, 5'd0), 32'd99, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    total++;
    if (bus.test_valid_out !== 1'b0 || bus.test_result !== 32'd30) begin
      bad++;
      $display("FAIL add_drop got=%h/%b want=%h/0", bus.test_result, bus.test_valid_out, 32'd30);
    end
  endtask

  task automatic test_writeback;
    step(mk(7'd1, 5'd1, 5'd0), 32'd15, 32'd25, 32'd0, 1'b1, 1'b1, 5'd5, 32'hAAAA_0000);
    total++;
    if (bus.test_result !== 32'd40 || bus.rf_r1 !== 32'd40) begin
      bad++;
      $display("FAIL wb_add got=%h rf=%h want=%h", bus.test_result, bus.rf_r1, 32'd40);
    end
    step(mk(7'd0, 5'd0, 5'd5), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd7, 32'd0);
    total++;
    if (bus.rf_r2 !== 32'd40) begin
      bad++;
      $display("FAIL wb_r2 got=%h want=%h", bus.rf_r2, 32'd40);
    end
    step(mk(7'd0, 5'd0, 5'd5), 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    total++;
    if (bus.rf_r1 !== 32'hDEAD_BEEF || bus.rf_r2 !== 32'd40) begin
      bad++;
      $display("FAIL ext_wr got=%h/%h want=%h/%h", bus.rf_r1, bus.rf_r2, 32'hDEAD_BEEF, 32'd40);
    end
    step(mk(7'd1, 5'd1, 5'd0), 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 5'd0, 32'h1234);
    step(mk(7'd1, 5'd1, 5'd0), 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd0, 32'h1234);
    total++;
    if (bus.rf_r1 !== 32'd0) begin
      bad++;
      $display("FAIL rf0_zero got=%h want=0", bus.rf_r1);
    end
    // Write-back wins over external data when both are present.
    step(mk(7'd1, 5'd1, 5'd0), 32'd6, 32'd7, 32'd0, 1'b1, 1'b1, 5'd9, 32'h5555_5555);
    total++;
    if (bus.rf_r1 !== 32'd13) begin
      bad++;
      $display("FAIL wb_priority got=%h want=%h", bus.rf_r1, 32'd13);
    end
  endtask

  task automatic test_alu;
    vec_t v [10];
    v[0] = '{7'd1, 5'd2, 32'd100, 32'd30, 32'd0, 32'd70};
    v[1] = '{7'd1, 5'd3, 32'd12, 32'd5, 32'd0, 32'd60};
    v[2] = '{7'd1, 5'd3, 32'h10000, 32'h10000, 32'd0, 32'd0};
    v[3] = '{7'd1, 5'd4, 32'hF0F0, 32'hFF00, 32'd0, 32'hF000};
    v[4] = '{7'd1, 5'd5, 32'hF0F0, 32'hFF00, 32'd0, 32'hFFF0};
    v[5] = '{7'd1, 5'd6, 32'hF0F0, 32'hFF00, 32'd0, 32'h0FF0};
    v[6] = '{7'd1, 5'd7, 32'd1, 32'd33, 32'd0, 32'd2};
    v[7] = '{7'd1, 5'd8, 32'h8000_0000, 32'd31, 32'd0, 32'd1};
    v[8] = '{7'd1, 5'd9, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000};
    v[9] = '{7'd1, 5'd2, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      step(mk(v[i].cls, v[i].fn, 5'd0), v[i].a, v[i].b, v[i].c, 1'b1, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus.test_result !== v[i].exp || bus.test_valid_out !== 1'b1) begin
        bad++;
        $display("FAIL alu[%0d] got=%h want=%h", i, bus.test_result, v[i].exp);
      end
    end
  endtask

  task automatic test_act;
    vec_t v [7];
    v[0] = '{7'd2, 5'd11, 32'd25, 32'd0, 32'd0, 32'd25};
    v[1] = '{7'd2, 5'd11, 32'hFFFF_FFE7, 32'd0, 32'd0, 32'd0};
    v[2] = '{7'd2, 5'd12, 32'hFFFF_FFFB, 32'd3, 32'd0, 32'd3};
    v[3] = '{7'd2, 5'd13, 32'hFFFF_FFFB, 32'd3, 32'd0, 32'hFFFF_FFFB};
    v[4] = '{7'd2, 5'd14, 32'd3, 32'd4, 32'd5, 32'd17};
    v[5] = '{7'd2, 5'd14, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'd1};
    v[6] = '{7'd2, 5'd1, 32'd3, 32'd4, 32'd5, 32'd0};
    for (int i = 0; i < 7; i++) begin
      step(mk(v[i].cls, v[i].fn, 5'd0), v[i].a, v[i].b, v[i].c, 1'b1, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus.test_result !== v[i].exp) begin
        bad++;
        $display("FAIL act[%0d] got=%h want=%h", i, bus.test_result, v[i].exp);
      end
    end
  endtask

  task automatic test_cmp;
    vec_t v [8];
    v[0] = '{7'h10, 5'd1, 32'd42, 32'd42, 32'd0, 32'd1};
    v[1] = '{7'h10, 5'd1, 32'd42, 32'd0, 32'd0, 32'd0};
    v[2] = '{7'h10, 5'd2, 32'd42, 32'd0, 32'd0, 32'd1};
    v[3] = '{7'h10, 5'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
    v[4] = '{7'h10, 5'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    v[5] = '{7'h10, 5'd4, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
    v[6] = '{7'h10, 5'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    v[7] = '{7'h10, 5'd5, 32'd5, 32'd5, 32'd0, 32'd1};
    for (int i = 0; i < 8; i++) begin
      step(mk(v[i].cls, v[i].fn, 5'd0), v[i].a, v[i].b, v[i].c, 1'b1, 1'b0, 5'd0, 32'd0);
      total++;
      if (bus.test_result !== v[i].exp) begin
        bad++;
        $display("FAIL cmp[%0d] got=%h want=%h", i, bus.test_result, v[i].exp);
      end
    end
  endtask

  task automatic test_unknown;
    step(mk(7'd1, 5'd1, 5'd0), 32'd8, 32'd8, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(mk(7'h7F, 5'd1, 5'd0), 32'd8, 32'd8, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    total++;
    if (bus.test_result !== 32'd0 || bus.test_valid_out !== 1'b1) begin
      bad++;
      $display("FAIL unk_class got=%h/%b want=0/1", bus.test_result, bus.test_valid_out);
    end
    step(mk(7'd1, 5'd1, 5'd0) | 32'hF800_03FF, 32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    total++;
    if (bus.test_result !== 32'd5) begin
      bad++;
      $display("FAIL ignored_bits got=%h want=%h", bus.test_result, 32'd5);
    end
    step(mk(7'd1, 5'd0, 5'd0), 32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    total++;
    if (bus.test_result !== 32'd0) begin
      bad++;
      $display("FAIL unk_func got=%h want=0", bus.test_result);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [4];
    exp[0] = 32'd7;
    exp[1] = 32'd1;
    exp[2] = 32'd12;
    exp[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(mk(7'd1, 5'd1, 5'd0), 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 5'd10 + 5'(i), 32'd0);
        1: step(mk(7'd1, 5'd2, 5'd0), 32'd4, 32'd3, 32'd0, 1'b1, 1'b1, 5'd10 + 5'(i), 32'd0);
        2: step(mk(7'd1, 5'd3, 5'd0), 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 5'd10 + 5'(i), 32'd0);
        default: step(mk(7'h10, 5'd3, 5'd0), 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 5'd10 + 5'(i), 32'd0);
      endcase
      total++;
      if (bus.test_result !== exp[i] || bus.rf_r1 !== exp[i] || bus.test_valid_out !== 1'b1) begin
        bad++;
        $display("FAIL b2b[%0d] got=%h rf=%h want=%h", i, bus.test_result, bus.rf_r1, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(mk(7'd0, 5'd0, 5'd0), 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h55);
    step(mk(7'd1, 5'd1, 5'd0), 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 5'd3, 32'd0);
    total++;
    if (bus.rf_r1 !== 32'h55 || bus.test_result !== 32'd3) begin
      bad++;
      $display("FAIL pre_rst got=%h/%h want=%h/%h", bus.rf_r1, bus.test_result, 32'h55, 32'd3);
    end
    rst = 1'b1;
    step(mk(7'd1, 5'd1, 5'd0), 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 5'd3, 32'd0);
    rst = 1'b0;
    total++;
    if (bus.test_result !== 32'd0 || bus.test_valid_out !== 1'b0 || bus.rf_r1 !== 32'd0) begin
      bad++;
      $display("FAIL rst_mid got=%h/%b rf=%h want=0/0 rf=0", bus.test_result,
               bus.test_valid_out, bus.rf_r1);
    end
    step(mk(7'd0, 5'd0, 5'd0), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd10, 32'd0);
    total++;
    if (bus.rf_r1 !== 32'd0) begin
      bad++;
      $display("FAIL rst_rf10 got=%h want=0", bus.rf_r1);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.test_opcode = 32'd0;
    bus.test_op1    = 32'd0;
    bus.test_op2    = 32'd0;
    bus.test_op3    = 32'd0;
    bus.test_valid  = 1'b0;
    bus.rf_wr_en    = 1'b0;
    bus.rf_wr_addr  = 5'd0;
    bus.rf_wr_data  = 32'd0;
    @(negedge clk);
    test_reset();
    test_add_hold();
    test_writeback();
    test_alu();
    test_act();
    test_cmp();
    test_unknown();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
